// File: rtl/trng_bit_collector.sv
// TRNG bit collector: periodic sampling of a synchronised ring-oscillator bit,
// optional von Neumann debiasing, repetition-count health test, word output.
module trng_bit_collector #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REP_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              rnd_bit,
  input  logic [15:0]       sample_cnt,
  input  logic              vn_bypass,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              rep_err
);

  localparam int unsigned BW = $clog2(DATA_W + 1);

  typedef enum logic {VN_IDLE, VN_HALF} vn_state_t;

  vn_state_t         vn_q, vn_d;
  logic [15:0]       samp_q;
  logic [15:0]       period_m1;
  logic              strobe;
  logic [7:0]        rep_q, rep_next;
  logic              last_q;
  logic              rep_hit;
  logic              flush;
  logic              stored_q;
  logic              emit;
  logic              emit_bit;
  logic [DATA_W-1:0] shreg;
  logic [BW-1:0]     bitcnt;
  logic              full;
  logic              transfer;
  logic              accept;

  // >= rather than == so a shortened period strobes at once and wraps
  assign period_m1 = (sample_cnt == 16'd0) ? 16'd0 : sample_cnt - 16'd1;
  assign strobe    = enable && (samp_q >= period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       samp_q <= '0;
    else if (!enable) samp_q <= '0;
    else if (strobe)  samp_q <= '0;
    else              samp_q <= samp_q + 16'd1;
  end

  always_comb begin
    rep_next = rep_q;
    if (rep_q == 8'd0 || rnd_bit != last_q) rep_next = 8'd1;
    else if (rep_q != 8'(REP_LIMIT))        rep_next = rep_q + 8'd1;
  end

  assign rep_hit = strobe && !rep_err && (rep_next == 8'(REP_LIMIT));
  assign flush   = rep_hit || rep_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q   <= '0;
      last_q  <= 1'b0;
      rep_err <= 1'b0;
    end else if (!enable) begin
      rep_q   <= '0;
      last_q  <= 1'b0;
      rep_err <= 1'b0;
    end else begin
      if (strobe) begin
        rep_q  <= rep_next;
        last_q <= rnd_bit;
      end
      if (rep_hit) rep_err <= 1'b1;
    end
  end

  always_comb begin
    vn_d     = vn_q;
    emit     = 1'b0;
    emit_bit = rnd_bit;
    if (strobe && !flush) begin
      if (vn_bypass) begin
        emit = 1'b1;
      end else begin
        case (vn_q)
          VN_IDLE: vn_d = VN_HALF;
          VN_HALF: begin
            vn_d = VN_IDLE;
            if (rnd_bit != stored_q) begin
              emit     = 1'b1;
              emit_bit = stored_q;
            end
          end
          default: vn_d = VN_IDLE;
        endcase
      end
    end
    if (flush) vn_d = VN_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vn_q     <= VN_IDLE;
      stored_q <= 1'b0;
    end else if (!enable) begin
      vn_q     <= VN_IDLE;
      stored_q <= 1'b0;
    end else begin
      vn_q <= vn_d;
      if (strobe && !flush && !vn_bypass && vn_q == VN_IDLE) stored_q <= rnd_bit;
    end
  end

  // A bit arriving on the transfer edge starts the next word instead of being lost
  assign full     = (bitcnt == BW'(DATA_W));
  assign transfer = enable && !flush && full && (!data_valid || data_ready);
  assign accept   = emit && (!full || transfer);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bitcnt     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      if (!enable || flush) begin
        shreg  <= '0;
        bitcnt <= '0;
      end else begin
        if (accept) shreg <= {shreg[DATA_W-2:0], emit_bit};
        if (transfer)    bitcnt <= accept ? BW'(1) : '0;
        else if (accept) bitcnt <= bitcnt + BW'(1);
      end
      if (transfer) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trng_bit_collector.sv
// Bench for trng_bit_collector: vector table through a word scoreboard plus
// directed sequences for timing, backpressure, health test and reset.
module tb_trng_bit_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       rnd_bit;
  logic [15:0] sample_cnt;
  logic       vn_bypass;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       rep_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic        byp;
    logic [31:0] raw;
    int          n;
    int          nw;
    logic [7:0]  w0;
    logic [7:0]  w1;
  } vec_t;

  vec_t tbl[6];

  trng_bit_collector #(.DATA_W(8), .REP_LIMIT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .rnd_bit    (rnd_bit),
    .sample_cnt (sample_cnt),
    .vn_bypass  (vn_bypass),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .rep_err    (rep_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A word is taken on any edge where valid and ready are both high
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_word: got %0h, expected none", data_out);
      end else begin
        chk("word", {56'd0, data_out}, {56'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe on the next edge carrying b
  task automatic send(input logic b);
    rnd_bit    = b;
    sample_cnt = 16'd1;
    tick();
  endtask

  // Park the sample counter far away so no further strobes occur
  task automatic hold();
    sample_cnt = 16'hFFFF;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send(b[i]);
  endtask

  initial begin
    int cyc;
    logic seen_valid;
    logic [15:0] sc_tab [3];
    int          lat_tab[3];

    tbl[0] = '{1'b1, 32'h000000B2,  8, 1, 8'hB2, 8'h00};
    tbl[1] = '{1'b1, 32'h0000005A,  8, 1, 8'h5A, 8'h00};
    tbl[2] = '{1'b1, 32'h0000C33C, 16, 2, 8'hC3, 8'h3C};
    tbl[3] = '{1'b0, 32'h00078996, 20, 1, 8'h69, 8'h00};
    tbl[4] = '{1'b0, 32'h0000AA55, 16, 1, 8'hF0, 8'h00};
    tbl[5] = '{1'b1, 32'h0000FF00, 16, 2, 8'hFF, 8'h00};
    sc_tab  = '{16'd0, 16'd1, 16'd4};
    lat_tab = '{9, 9, 33};

    rst_n      = 1'b0;
    enable     = 1'b0;
    rnd_bit    = 1'b0;
    sample_cnt = 16'd1;
    vn_bypass  = 1'b1;
    data_ready = 1'b1;
    #12;
    chk("reset_data_out", {56'd0, data_out}, 64'd0);
    chk("reset_data_valid", {63'd0, data_valid}, 64'd0);
    chk("reset_rep_err", {63'd0, rep_err}, 64'd0);
    #10 rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      enable = 1'b0;
      tick();
      vn_bypass  = tbl[v].byp;
      data_ready = 1'b1;
      enable     = 1'b1;
      exp_q.push_back(tbl[v].w0);
      if (tbl[v].nw > 1) exp_q.push_back(tbl[v].w1);
      for (int i = 0; i < tbl[v].n; i++) send(tbl[v].raw[tbl[v].n - 1 - i]);
      hold();
      repeat (4) tick();
      enable = 1'b0;
      tick();
      chk($sformatf("vec%0d_outstanding", v), 64'(exp_q.size()), 64'd0);
    end

    // Strobe period: first word appears 1 edge after the 8th strobe edge
    for (int k = 0; k < 3; k++) begin
      enable     = 1'b0;
      data_ready = 1'b0;
      vn_bypass  = 1'b1;
      rnd_bit    = 1'b1;
      tick();
      sample_cnt = sc_tab[k];
      enable     = 1'b1;
      cyc        = 0;
      while (!data_valid && cyc < 100) begin
        tick();
        cyc++;
      end
      chk($sformatf("latency_sc%0d", sc_tab[k]), 64'(cyc), 64'(lat_tab[k]));
      exp_q.push_back(8'hFF);
      data_ready = 1'b1;
      enable     = 1'b0;
      repeat (2) tick();
    end

    // Backpressure across three words
    enable     = 1'b0;
    data_ready = 1'b0;
    vn_bypass  = 1'b1;
    tick();
    enable = 1'b1;
    send_byte(8'hB2);
    send(1'b0);
    chk("bp_first_word", {56'd0, data_out}, 64'hB2);
    send(1'b1); send(1'b0); send(1'b0); send(1'b1); send(1'b1); send(1'b0); send(1'b1);
    send_byte(8'hA5);
    hold();
    repeat (3) tick();
    chk("bp_valid_held", {63'd0, data_valid}, 64'd1);
    chk("bp_stable", {56'd0, data_out}, 64'hB2);
    exp_q.push_back(8'hB2);
    exp_q.push_back(8'h4D);
    data_ready = 1'b1;
    repeat (3) tick();
    chk("bp_drained", {63'd0, data_valid}, 64'd0);
    enable = 1'b0;
    tick();

    // Repetition-count health test with a stuck source
    vn_bypass = 1'b0;
    rnd_bit   = 1'b1;
    enable    = 1'b1;
    seen_valid = 1'b0;
    repeat (15) begin
      send(1'b1);
      seen_valid |= data_valid;
    end
    chk("rep_err_before_limit", {63'd0, rep_err}, 64'd0);
    send(1'b1);
    chk("rep_err_at_limit", {63'd0, rep_err}, 64'd1);
    repeat (14) begin
      send(1'b1);
      seen_valid |= data_valid;
    end
    chk("rep_no_valid", {63'd0, seen_valid}, 64'd0);
    chk("rep_err_sticky", {63'd0, rep_err}, 64'd1);
    enable = 1'b0;
    tick();
    chk("rep_err_cleared", {63'd0, rep_err}, 64'd0);

    // Asynchronous reset mid-word
    data_ready = 1'b0;
    vn_bypass  = 1'b1;
    enable     = 1'b1;
    send_byte(8'hB2);
    send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b1);
    hold();
    chk("pre_reset_word", {56'd0, data_out}, 64'hB2);
    #3 rst_n = 1'b0;
    #1;
    chk("async_data_out", {56'd0, data_out}, 64'd0);
    chk("async_data_valid", {63'd0, data_valid}, 64'd0);
    chk("async_rep_err", {63'd0, rep_err}, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    send(1'b0); send(1'b1); send(1'b1); send(1'b0); send(1'b1); send(1'b0); send(1'b0);
    hold();
    repeat (4) tick();
    chk("post_reset_partial", {63'd0, data_valid}, 64'd0);
    exp_q.push_back(8'h69);
    data_ready = 1'b1;
    send(1'b1);
    hold();
    repeat (4) tick();
    enable = 1'b0;
    tick();

    chk("final_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trng_bit_collector.md
TRNG_BIT_COLLECTOR -- requirements
Module: trng_bit_collector

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, output word width (legal range 2..64).
REQ-002 The block SHALL have parameter REP_LIMIT, default 16, repetition-count threshold on raw samples (legal range 2..255).
REQ-003 Reset is rst_n, asynchronous, active-low; the clock is clk.
REQ-004 Port clk  input  1  system clock.
REQ-005 Port rst_n  input  1  asynchronous active-low reset.
REQ-006 Port enable  input  1  collection enable; low clears the collection state.
REQ-007 Port rnd_bit  input  1  ring-oscillator bit, already synchronised to clk by a two-flop stage.
REQ-008 Port sample_cnt  input  16  sampling period in clk cycles; 0 SHALL be treated as 1.
REQ-009 Port vn_bypass  input  1  1 = skip von Neumann debiasing.
REQ-010 Port data_out  output  DATA_W  collected random word.
REQ-011 Port data_valid  output  1  data_out holds an unconsumed word.
REQ-012 Port data_ready  input  1  consumer accepts data_out when high with data_valid.
REQ-013 Port rep_err  output  1  sticky repetition-count health failure.

Function
REQ-014 The sample counter SHALL increment each enabled cycle and assert a one-cycle strobe when it equals max(sample_cnt,1)-1, then return to 0; the strobe captures rnd_bit as the raw sample.
REQ-015 A sample_cnt change SHALL take effect on the next compare; if the counter is already >= the new period, it SHALL strobe immediately and wrap to 0.
REQ-016 With vn_bypass=1, every raw sample SHALL be an emitted bit.
REQ-017 With vn_bypass=0, the von Neumann FSM SHALL have states VN_IDLE and VN_HALF.
REQ-018 In VN_IDLE, a strobe SHALL store the sample and move the FSM to VN_HALF.
REQ-019 In VN_HALF, a strobe SHALL emit the stored bit if the new sample differs from it, discard both samples if they are equal, and in either case return the FSM to VN_IDLE.
REQ-020 Emitted bits SHALL shift into the shift register LSB-side: shreg <= {shreg[DATA_W-2:0], bit}, and the 0..DATA_W bit counter SHALL increment.
REQ-021 When the bit counter equals DATA_W and data_valid is 0, or data_valid and data_ready are both 1 in the same cycle, then on the next edge the shift register SHALL transfer to data_out, data_valid SHALL be set, and the bit counter SHALL clear.
REQ-022 Latency from the strobe carrying the final bit to data_valid=1 SHALL be 2 cycles: 1 cycle to shift, 1 cycle to transfer.
REQ-023 While the bit counter equals DATA_W and the output is occupied, newly emitted bits SHALL be dropped; sampling and the VN FSM continue.
REQ-024 A data_valid&&data_ready handshake with no pending transfer SHALL clear data_valid on the next edge; data_out SHALL remain stable while data_valid=1 and data_ready=0.
REQ-025 The repetition counter SHALL count consecutive identical raw samples regardless of vn_bypass, restarting at 1 on a differing sample.
REQ-026 When the repetition counter reaches REP_LIMIT, rep_err SHALL set, and the shift register, bit counter and VN FSM SHALL be flushed in the same edge; while rep_err=1, no bits are emitted.
REQ-027 enable=0 SHALL synchronously clear the sample counter, VN FSM (to VN_IDLE), shift register, bit counter, repetition counter and rep_err; data_out and data_valid SHALL be retained until handshaked.
REQ-028 A strobe and a flush in the same cycle SHALL let the flush win, with the sample discarded.

Reset
REQ-029 Asserting rst_n low at any time, mid-word included, SHALL immediately set data_out=0, data_valid=0, rep_err=0, all counters=0, shift register=0 and the VN FSM to VN_IDLE.
REQ-030 After rst_n release, the first strobe SHALL occur max(sample_cnt,1) enabled cycles later.

Verification
REQ-031 DATA_W=8, vn_bypass=1, sample_cnt=1, rnd_bit pattern 1,0,1,1,0,0,1,0 -> data_valid high 2 cycles after the 8th sample, data_out=8'hB2.
REQ-032 vn_bypass=0, sample pairs 01,11,10,00,... -> only 0 and then 1 are emitted; the equal pairs produce no shift.
REQ-033 data_ready held 0 across two full words -> first word stable, second word transfers on the ready cycle, and bits of a third word are dropped.
REQ-034 REP_LIMIT=16, rnd_bit stuck at 1 -> rep_err=1 after the 16th strobe, and data_valid never rises; enable toggled low clears rep_err.
REQ-035 sample_cnt=0 versus sample_cnt=1 -> identical strobe timing; sample_cnt=4 -> strobe every 4th cycle.
REQ-036 rst_n asserted after 5 of 8 bits -> all outputs 0; a full new word is needed for data_valid.
